sync_counter_ctrl: RTL and testbench

Sequencing controller for the synchronous T-flip-flop counter datapath. It owns a WIDTH-bit counter whose bits toggle from the AND of the lower bits. The controller adds start/stop/pause control, up/down direction, a programmable load value and terminal count, and one-shot or auto-reload operation. Other blocks use it as a programmable interval timer/sequencer.

---
 rtl/sync_counter_ctrl.sv | 142 ++++++++++++++
 tb/tb_sync_counter_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sync_counter_ctrl.sv
// sync_counter_ctrl: sequencing controller around a WIDTH-bit synchronous
// T-flip-flop counter. It adds start/stop/pause control, up/down counting, a
// programmable load value and terminal count, and one-shot or auto-reload
// operation. Other blocks use it as a programmable interval timer.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        begin a run from IDLE or DONE (loads load_val)
//   stop         abort the run and return to IDLE (highest priority)
//   pause        freeze the count while high (RUN/HOLD)
//   dir          1 = count up, 0 = count down (sampled every cycle)
//   auto_reload  1 = reload and continue at terminal count, 0 = one-shot
//   load_val     value loaded on start and on reload
//   tc_val       terminal count value
//   q            registered count
//   state        IDLE=0, RUN=1, HOLD=2, DONE=3
//   busy         high in RUN or HOLD
//   done         one-cycle registered pulse at terminal count
module sync_counter_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] tc_val,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] cnt_step;
  logic             done_q, done_d;
  logic             rld_q, rld_d;

  // T-flip-flop toggle enables: bit i toggles when all lower bits are 1
  // (up) or all lower bits are 0 (down).
  always_comb begin
    tgl = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      logic en;
      en = 1'b1;
      for (int unsigned j = 0; j < i; j++) begin
        en = en & (dir ? cnt_q[j] : ~cnt_q[j]);
      end
      tgl[i] = en;
    end
  end

  assign cnt_step = cnt_q ^ tgl;

  // Terminal count in auto-reload mode is split over two edges: the first
  // pulses done and holds q at tc_val, the second (rld_q set) loads
  // load_val. This keeps q at tc_val for one cycle, gives a reload period
  // of (distance + 2) cycles, and makes done alternate when load == tc.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rld_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!stop && start) begin
          cnt_d   = load_val;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (rld_q) begin
          cnt_d = load_val;
        end else if (cnt_q == tc_val) begin
          done_d = 1'b1;
          if (auto_reload) begin
            rld_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else if (pause) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_step;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          cnt_d   = load_val;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rld_q   <= rld_d;
    end
  end

  assign q     = cnt_q;
  assign state = state_q;
  assign done  = done_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_sync_counter_ctrl.sv
// Self-checking bench for sync_counter_ctrl (WIDTH=4): a table of per-edge
// input/expected-output records, plus a hand-written async reset sequence.
module tb_sync_counter_ctrl;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start, stop, pause, dir, auto_reload;
  logic [W-1:0] load_val, tc_val;
  logic [W-1:0] q;
  logic [1:0]   state;
  logic         busy, done;

  int checks;
  int errors;

  sync_counter_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .dir         (dir),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .tc_val      (tc_val),
    .q           (q),
    .state       (state),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s_start;
    logic       s_stop;
    logic       s_pause;
    logic       s_dir;
    logic       s_auto;
    logic [3:0] s_load;
    logic [3:0] s_tc;
    logic [3:0] e_q;
    logic [1:0] e_state;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic sp, input logic pa,
                              input logic di, input logic au,
                              input logic [3:0] ld, input logic [3:0] tc,
                              input logic [3:0] eq, input logic [1:0] es,
                              input logic ed);
    vec_t v;
    v.s_start = st; v.s_stop = sp; v.s_pause = pa; v.s_dir = di; v.s_auto = au;
    v.s_load = ld; v.s_tc = tc; v.e_q = eq; v.e_state = es; v.e_done = ed;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq,
                         input logic [1:0] es, input logic ed);
    logic eb;
    eb = (es == 2'd1) || (es == 2'd2);
    chk({tag, ".q"},     int'(q),     int'(eq));
    chk({tag, ".state"}, int'(state), int'(es));
    chk({tag, ".done"},  int'(done),  int'(ed));
    chk({tag, ".busy"},  int'(busy),  int'(eb));
  endtask

  task automatic drive(input logic st, input logic sp, input logic pa,
                       input logic di, input logic au,
                       input logic [3:0] ld, input logic [3:0] tc);
    start = st; stop = sp; pause = pa; dir = di; auto_reload = au;
    load_val = ld; tc_val = tc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0);

    // start/stop/pause/dir/auto/load/tc  ->  q/state/done
    // 1: up 2..5, one-shot
    add(1,0,0,1,0, 2,5,  2,1,0);
    add(0,0,0,1,0, 2,5,  3,1,0);
    add(0,0,0,1,0, 2,5,  4,1,0);
    add(0,0,0,1,0, 2,5,  5,1,0);
    add(0,0,0,1,0, 2,5,  5,3,1);
    add(0,0,0,1,0, 2,5,  5,3,0);
    // 5: stop beats start in DONE
    add(1,1,0,1,0, 2,5,  5,0,0);
    // 2: down 3..0 auto-reload, done once per 5 cycles
    add(1,0,0,0,1, 3,0,  3,1,0);
    add(0,0,0,0,1, 3,0,  2,1,0);
    add(0,0,0,0,1, 3,0,  1,1,0);
    add(0,0,0,0,1, 3,0,  0,1,0);
    add(0,0,0,0,1, 3,0,  0,1,1);
    add(0,0,0,0,1, 3,0,  3,1,0);
    add(0,0,0,0,1, 3,0,  2,1,0);
    add(0,0,0,0,1, 3,0,  1,1,0);
    add(0,0,0,0,1, 3,0,  0,1,0);
    add(0,0,0,0,1, 3,0,  0,1,1);
    add(0,0,0,0,1, 3,0,  3,1,0);
    // 5: start in RUN ignored, keeps counting
    add(1,0,0,0,1, 3,0,  2,1,0);
    add(0,1,0,0,1, 3,0,  2,0,0);
    // 3: up wrap 14,15,0,1
    add(1,0,0,1,0, 14,1, 14,1,0);
    add(0,0,0,1,0, 14,1, 15,1,0);
    add(0,0,0,1,0, 14,1,  0,1,0);
    add(0,0,0,1,0, 14,1,  1,1,0);
    add(0,0,0,1,0, 14,1,  1,3,1);
    add(0,1,0,1,0, 14,1,  1,0,0);
    // 4: pause at q=6 for 3 cycles, then tc together with pause
    add(1,0,0,1,0, 6,9,  6,1,0);
    add(0,0,1,1,0, 6,9,  6,2,0);
    add(0,0,1,1,0, 6,9,  6,2,0);
    add(0,0,1,1,0, 6,9,  6,2,0);
    add(0,0,0,1,0, 6,9,  6,1,0);
    add(0,0,0,1,0, 6,9,  7,1,0);
    add(0,0,0,1,0, 6,9,  8,1,0);
    add(0,0,0,1,0, 6,9,  9,1,0);
    add(0,0,1,1,0, 6,9,  9,3,1);
    // dir change mid-run applies on the same edge
    add(1,0,0,1,0, 4,9,  4,1,0);
    add(0,0,0,0,0, 4,9,  3,1,0);
    add(0,0,0,1,0, 4,9,  4,1,0);
    add(0,1,0,1,0, 4,9,  4,0,0);
    // load == tc with auto-reload: done every other cycle
    add(1,0,0,1,1, 7,7,  7,1,0);
    add(0,0,0,1,1, 7,7,  7,1,1);
    add(0,0,0,1,1, 7,7,  7,1,0);
    add(0,0,0,1,1, 7,7,  7,1,1);
    add(0,1,0,1,1, 7,7,  7,0,0);

    // reset state
    #12;
    chk_all("reset", 4'd0, 2'd0, 1'b0);
    #5 rst = 1'b1;   // released between edges (t=17)

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s_start, vecs[i].s_stop, vecs[i].s_pause, vecs[i].s_dir,
            vecs[i].s_auto, vecs[i].s_load, vecs[i].s_tc);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_q, vecs[i].e_state, vecs[i].e_done);
    end

    // 6: async reset mid-run at q=9
    drive(1, 0, 0, 1, 0, 4'd9, 4'd15);
    @(posedge clk); #1;
    chk_all("rst_pre", 4'd9, 2'd1, 1'b0);
    drive(0, 0, 0, 1, 0, 4'd9, 4'd15);
    #3 rst = 1'b0;
    #1;
    chk_all("rst_async", 4'd0, 2'd0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_held", 4'd0, 2'd0, 1'b0);
    #2 rst = 1'b1;
    drive(1, 0, 0, 1, 0, 4'd2, 4'd15);
    @(posedge clk); #1;
    chk_all("rst_restart", 4'd2, 2'd1, 1'b0);
    drive(0, 0, 0, 1, 0, 4'd2, 4'd15);
    @(posedge clk); #1;
    chk_all("rst_count", 4'd3, 2'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
